sdram_rw_arbiter: RTL

Schedules the single SDRAM command engine between three requesters: the periodic auto-refresh, the write-burst request, and the read-burst request coming from the SDRAM FIFO control block.
It latches the winning request's address and length, and starts the engine with a one-cycle pulse.
During the data phase it generates the burst-exact sdram_wr_ack / sdram_rd_ack windows that drain the write FIFO and fill the read FIFO.
It sits between the FIFO control block and the SDRAM command/timing engine.

---
 rtl/sdram_rw_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sdram_rw_arbiter.sv
// Arbiter for the shared SDRAM command engine: periodic refresh, write bursts and read bursts.
// Latches the winning request, pulses the engine start and frames the burst-exact ack windows.
module sdram_rw_arbiter #(
  parameter int REF_PERIOD    = 781,
  parameter int WR_STREAK_MAX = 4
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        sdram_wr_req,
  input  logic [23:0] sdram_wr_addr,
  input  logic [9:0]  wr_length,
  input  logic        sdram_rd_req,
  input  logic [23:0] sdram_rd_addr,
  input  logic [9:0]  rd_length,
  output logic        sdram_wr_ack,
  output logic        sdram_rd_ack,
  output logic        eng_start,
  output logic [1:0]  eng_op,
  output logic [23:0] eng_addr,
  output logic [9:0]  eng_len,
  input  logic        eng_data_go,
  input  logic        eng_done,
  output logic        ref_overrun,
  output logic [1:0]  dbg_state
);

  localparam int RCW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int SCW = $clog2(WR_STREAK_MAX + 1);
  localparam logic [RCW-1:0] REF_LAST   = RCW'(REF_PERIOD - 1);
  localparam logic [SCW-1:0] STREAK_MAX = SCW'(WR_STREAK_MAX);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DATA = 2'd2} state_t;
  typedef enum logic [1:0] {OP_REF = 2'd0, OP_WR = 2'd1, OP_RD = 2'd2} op_t;

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [RCW-1:0]  ref_cnt_q, ref_cnt_d;
  logic            ref_pend_q, ref_pend_d;
  logic            ref_ovr_q, ref_ovr_d;
  logic [SCW-1:0]  streak_q, streak_d;
  logic [9:0]      beat_q, beat_d;
  logic            start_q, start_d;
  logic [23:0]     addr_q, addr_d;
  logic [9:0]      len_q, len_d;

  logic ref_expire;
  logic grant_ref;
  logic wr_ok;
  logic rd_ok;

  assign ref_expire = sdram_init_done && (ref_cnt_q == REF_LAST);
  assign wr_ok      = sdram_wr_req && (wr_length != 10'd0);
  assign rd_ok      = sdram_rd_req && (rd_length != 10'd0);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    streak_d  = streak_q;
    beat_d    = beat_q;
    start_d   = 1'b0;
    addr_d    = addr_q;
    len_d     = len_q;
    grant_ref = 1'b0;
    ref_cnt_d = sdram_init_done ? (ref_expire ? '0 : ref_cnt_q + 1'b1) : '0;

    case (state_q)
      ST_IDLE: begin
        if (sdram_init_done) begin
          if (ref_pend_q) begin
            grant_ref = 1'b1;
            state_d   = ST_BUSY;
            start_d   = 1'b1;
            op_d      = OP_REF;
            addr_d    = '0;
            len_d     = '0;
          end else if (rd_ok && (streak_q == STREAK_MAX)) begin
            state_d  = ST_BUSY;
            start_d  = 1'b1;
            op_d     = OP_RD;
            addr_d   = sdram_rd_addr;
            len_d    = rd_length;
            streak_d = '0;
          end else if (wr_ok) begin
            state_d  = ST_BUSY;
            start_d  = 1'b1;
            op_d     = OP_WR;
            addr_d   = sdram_wr_addr;
            len_d    = wr_length;
            // The streak only matters while a read is waiting behind the writes.
            streak_d = rd_ok ? ((streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1) : '0;
          end else if (rd_ok) begin
            state_d  = ST_BUSY;
            start_d  = 1'b1;
            op_d     = OP_RD;
            addr_d   = sdram_rd_addr;
            len_d    = rd_length;
            streak_d = '0;
          end
        end
      end
      ST_BUSY: begin
        if (eng_done) begin
          state_d = ST_IDLE;
        end else if (eng_data_go && (op_q != OP_REF)) begin
          state_d = ST_DATA;
          beat_d  = len_q;
        end
      end
      ST_DATA: begin
        // eng_done here is an abort: drop the window at once.
        if (eng_done) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else if (beat_q == 10'd1) begin
          state_d = ST_BUSY;
          beat_d  = '0;
        end else begin
          beat_d = beat_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ref_pend_d = (ref_pend_q && !grant_ref) || ref_expire;
    ref_ovr_d  = ref_ovr_q || (ref_expire && ref_pend_q);
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_REF;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      ref_ovr_q  <= 1'b0;
      streak_q   <= '0;
      beat_q     <= '0;
      start_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ref_ovr_q  <= ref_ovr_d;
      streak_q   <= streak_d;
      beat_q     <= beat_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
    end
  end

  assign sdram_wr_ack = (state_q == ST_DATA) && (op_q == OP_WR);
  assign sdram_rd_ack = (state_q == ST_DATA) && (op_q == OP_RD);
  assign eng_start    = start_q;
  assign eng_op       = op_q;
  assign eng_addr     = addr_q;
  assign eng_len      = len_q;
  assign ref_overrun  = ref_ovr_q;
  assign dbg_state    = state_q;

endmodule
